clk_tick_gen: RTL and testbench

Parametrised clock-enable generator for the board top level, replacing the single fixed divide-by-10000 derived clock. All logic runs on the board clock `clk`. It produces `NCH` independent single-cycle tick strobes plus 50%-style phase outputs, with runtime-programmable divisors. Channel 0 drives the RISC-V core and supports run/halt/single-step modes for debug. The remaining channels free-run, for example for seven-segment refresh.

---
 rtl/clk_tick_gen.sv | 159 +++++++++++++++
 tb/tb_clk_tick_gen.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_gen.sv
// Parametrised clock-enable generator: NCH tick strobes and square-wave phases with runtime divisors.
// Channel 0 has run/halt modes; STEP mode is built only when CLK_TICK_GEN_STEP_EN is defined.
module clk_tick_gen #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned NCH         = 2,
    parameter int unsigned DIV_DEFAULT = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   div_we_i,
    input  logic [CNT_W-1:0] div_wdata_i,
    input  logic [1:0]       mode_i,
    input  logic             step_req_i,
    output logic [NCH-1:0]   tick_o,
    output logic [NCH-1:0]   phase_o,
    output logic             halted_o,
    output logic [31:0]      tick0_count_o
);

    typedef enum logic [1:0] {
        ModeRun  = 2'b00,
        ModeHalt = 2'b01,
        ModeStep = 2'b10,
        ModeRsvd = 2'b11
    } mode_e;

    mode_e          mode;
    logic [NCH-1:0] ch_hold;
    logic [NCH-1:0] ch_clear;
    logic [NCH-1:0] ch_fire;
    logic [NCH-1:0] tick_all;
    logic [NCH-1:0] phase_all;
    logic           halted_q;
    logic [31:0]    tick0_count_q;
    logic [31:0]    tick0_count_d;
    logic           step_fire;

    assign mode = mode_e'(mode_i);

`ifdef CLK_TICK_GEN_STEP_EN
    logic step_prev_q;
    logic step_mode_q;

    // A rising edge only counts if STEP was already active on the previous edge.
    assign step_fire = step_req_i & ~step_prev_q & step_mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_prev_q <= 1'b0;
            step_mode_q <= 1'b0;
        end else begin
            step_prev_q <= step_req_i;
            step_mode_q <= (mode == ModeStep);
        end
    end
`else
    logic unused_step_req;

    assign unused_step_req = step_req_i;
    assign step_fire       = 1'b0;
`endif

    // Channel 0 control; the other channels always count.
    always_comb begin
        ch_hold  = '0;
        ch_clear = '0;
        ch_fire  = '0;
        case (mode)
            ModeRun: begin
                ch_clear[0] = halted_q;
            end
`ifdef CLK_TICK_GEN_STEP_EN
            ModeStep: begin
                ch_clear[0] = 1'b1;
                ch_fire[0]  = step_fire;
            end
`endif
            default: begin
                ch_hold[0] = 1'b1;
            end
        endcase
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] div_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] div_eff;
        logic [CNT_W-1:0] div_eff_d;
        logic             tick_q;
        logic             tick_d;
        logic             phase_q;
        logic             phase_d;
        logic             wrap;

        assign div_eff   = (div_q == '0) ? CNT_W'(1) : div_q;
        assign div_eff_d = (div_d == '0) ? CNT_W'(1) : div_d;
        assign wrap      = (cnt_q == div_eff - CNT_W'(1));

        // A divisor write beats every other update, including a wrap in the same cycle.
        always_comb begin
            div_d  = div_q;
            cnt_d  = cnt_q;
            tick_d = 1'b0;
            if (div_we_i[i]) begin
                div_d = div_wdata_i;
                cnt_d = '0;
            end else if (ch_clear[i]) begin
                cnt_d  = '0;
                tick_d = ch_fire[i];
            end else if (!ch_hold[i]) begin
                if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        assign phase_d = (!div_we_i[i] && ch_hold[i]) ? phase_q : (cnt_d < (div_eff_d >> 1));

        always_ff @(posedge clk) begin
            if (rst) begin
                div_q   <= CNT_W'(DIV_DEFAULT);
                cnt_q   <= '0;
                tick_q  <= 1'b0;
                phase_q <= 1'b0;
            end else begin
                div_q   <= div_d;
                cnt_q   <= cnt_d;
                tick_q  <= tick_d;
                phase_q <= phase_d;
            end
        end

        assign tick_all[i]  = tick_q;
        assign phase_all[i] = phase_q;
    end

    assign tick0_count_d = tick0_count_q + {31'b0, tick_all[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q      <= 1'b0;
            tick0_count_q <= '0;
        end else begin
            halted_q      <= (mode != ModeRun);
            tick0_count_q <= tick0_count_d;
        end
    end

    assign tick_o        = tick_all;
    assign phase_o       = phase_all;
    assign halted_o      = halted_q;
    assign tick0_count_o = tick0_count_q;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed self-checking bench for clk_tick_gen (NCH=2, default divisor 10000).
// Cycle n is the n-th rising edge after reset release; outputs are sampled 1 time unit after it.
module tb_clk_tick_gen;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned NCH   = 2;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] div_we;
    logic [31:0]    div_wdata;
    logic [1:0]     mode;
    logic           step_req;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] phase;
    logic           halted;
    logic [31:0]    tick0_count;

    int checks   = 0;
    int failures = 0;

    clk_tick_gen #(
        .CNT_W      (CNT_W),
        .NCH        (NCH),
        .DIV_DEFAULT(10000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .div_we_i     (div_we),
        .div_wdata_i  (div_wdata),
        .mode_i       (mode),
        .step_req_i   (step_req),
        .tick_o       (tick),
        .phase_o      (phase),
        .halted_o     (halted),
        .tick0_count_o(tick0_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        div_we    = '0;
        div_wdata = '0;
        mode      = 2'b00;
        step_req  = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        div_we    = '0;
        div_wdata = '0;
        mode      = 2'b01;
        step_req  = 1'b0;
        cyc();
        cyc();
        checks++;
        if (tick !== 2'b00) begin
            failures++;
            $display("FAIL reset tick: got %b, required 00", tick);
        end
        checks++;
        if (phase !== 2'b00) begin
            failures++;
            $display("FAIL reset phase: got %b, required 00", phase);
        end
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL reset halted: got %b, required 0", halted);
        end
        checks++;
        if (tick0_count !== 32'd0) begin
            failures++;
            $display("FAIL reset tick0_count: got %0d, required 0", tick0_count);
        end
        mode = 2'b00;
        rst  = 1'b0;
        cyc();
        checks++;
        if (tick !== 2'b00 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset cycle1: tick=%b halted=%b, required 00 and 0", tick, halted);
        end
    endtask

    task automatic test_run_default();
        int   bad_t0 = 0;
        int   bad_t1 = 0;
        int   bad_ph = 0;
        int   ph_hi  = 0;
        logic exp_t;
        logic exp_p;
        do_reset();
        for (int c = 1; c <= 30000; c++) begin
            cyc();
            exp_t = ((c % 10000) == 0);
            exp_p = ((c % 10000) < 5000);
            if (tick[0] !== exp_t) bad_t0++;
            if (tick[1] !== exp_t) bad_t1++;
            if (phase[0] !== exp_p || phase[1] !== exp_p) bad_ph++;
            if (c <= 10000 && phase[0] === 1'b1) ph_hi++;
        end
        checks++;
        if (bad_t0 !== 0) begin
            failures++;
            $display("FAIL run_default tick0: %0d wrong cycles, required 0", bad_t0);
        end
        checks++;
        if (bad_t1 !== 0) begin
            failures++;
            $display("FAIL run_default tick1: %0d wrong cycles, required 0", bad_t1);
        end
        checks++;
        if (bad_ph !== 0) begin
            failures++;
            $display("FAIL run_default phase: %0d wrong cycles, required 0", bad_ph);
        end
        checks++;
        if (ph_hi !== 5000) begin
            failures++;
            $display("FAIL run_default phase0 high: got %0d of 10000, required 5000", ph_hi);
        end
        checks++;
        if (tick0_count !== 32'd2) begin
            failures++;
            $display("FAIL run_default count@30000: got %0d, required 2", tick0_count);
        end
        cyc();
        checks++;
        if (tick0_count !== 32'd3) begin
            failures++;
            $display("FAIL run_default count@30001: got %0d, required 3", tick0_count);
        end
    endtask

    task automatic test_div_write();
        int   bad_t0 = 0;
        int   bad_t1 = 0;
        int   n_t1   = 0;
        logic exp0;
        logic exp1;
        do_reset();
        for (int c = 1; c <= 10000; c++) begin
            if (c == 100) begin
                div_we    = 2'b10;
                div_wdata = 32'd3;
            end else begin
                div_we = 2'b00;
            end
            cyc();
            exp0 = (c == 10000);
            exp1 = (c > 100) && (((c - 100) % 3) == 0);
            if (tick[0] !== exp0) bad_t0++;
            if (tick[1] !== exp1) bad_t1++;
            if (c >= 101 && c <= 109 && tick[1] === 1'b1) n_t1++;
        end
        div_we = 2'b00;
        checks++;
        if (bad_t1 !== 0) begin
            failures++;
            $display("FAIL div_write tick1: %0d wrong cycles, required 0", bad_t1);
        end
        checks++;
        if (n_t1 !== 3) begin
            failures++;
            $display("FAIL div_write tick1 in 101..109: got %0d, required 3", n_t1);
        end
        checks++;
        if (bad_t0 !== 0) begin
            failures++;
            $display("FAIL div_write tick0: %0d wrong cycles, required 0", bad_t0);
        end
    endtask

    task automatic test_div_zero_one();
        int   bad_t  = 0;
        int   bad_ph = 0;
        logic exp_t;
        logic wrap_tick;
        do_reset();
        wrap_tick = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) begin
                div_we    = 2'b11;
                div_wdata = 32'd0;
            end else if (c == 12) begin
                div_we    = 2'b11;
                div_wdata = 32'd1;
            end else begin
                div_we = 2'b00;
            end
            cyc();
            exp_t = (c != 1) && (c != 12);
            if (tick !== {exp_t, exp_t}) bad_t++;
            if (phase !== 2'b00) bad_ph++;
            if (c == 12) wrap_tick = tick[0];
        end
        div_we = 2'b00;
        checks++;
        if (bad_t !== 0) begin
            failures++;
            $display("FAIL div_zero_one tick: %0d wrong cycles, required 0", bad_t);
        end
        checks++;
        if (bad_ph !== 0) begin
            failures++;
            $display("FAIL div_zero_one phase: %0d cycles nonzero, required 0", bad_ph);
        end
        checks++;
        if (wrap_tick !== 1'b0) begin
            failures++;
            $display("FAIL div_zero_one write_on_wrap: tick0=%b, required 0", wrap_tick);
        end
        checks++;
        if (tick0_count !== 32'd17) begin
            failures++;
            $display("FAIL div_zero_one count: got %0d, required 17", tick0_count);
        end
    endtask

    task automatic test_halt_run();
        int   bad_t0 = 0;
        int   bad_t1 = 0;
        int   bad_h  = 0;
        int   bad_ph = 0;
        logic exp0;
        logic exp1;
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) begin
                div_we    = 2'b11;
                div_wdata = 32'd4;
            end else begin
                div_we = 2'b00;
            end
            mode = (c >= 11 && c <= 30) ? 2'b01 : 2'b00;
            cyc();
            exp0 = (c == 5) || (c == 9) || (c == 35) || (c == 39);
            exp1 = (c > 1) && (((c - 1) % 4) == 0);
            if (tick[0] !== exp0) bad_t0++;
            if (tick[1] !== exp1) bad_t1++;
            if (halted !== (c >= 11 && c <= 30)) bad_h++;
            if (c >= 10 && c <= 30 && phase[0] !== 1'b1) bad_ph++;
        end
        mode = 2'b00;
        checks++;
        if (bad_t0 !== 0) begin
            failures++;
            $display("FAIL halt_run tick0: %0d wrong cycles, required 0", bad_t0);
        end
        checks++;
        if (bad_t1 !== 0) begin
            failures++;
            $display("FAIL halt_run tick1: %0d wrong cycles, required 0", bad_t1);
        end
        checks++;
        if (bad_h !== 0) begin
            failures++;
            $display("FAIL halt_run halted: %0d wrong cycles, required 0", bad_h);
        end
        checks++;
        if (bad_ph !== 0) begin
            failures++;
            $display("FAIL halt_run phase0_hold: %0d wrong cycles, required 0", bad_ph);
        end
        checks++;
        if (tick0_count !== 32'd4) begin
            failures++;
            $display("FAIL halt_run count: got %0d, required 4", tick0_count);
        end
    endtask

    task automatic test_step();
        int   bad_t0 = 0;
        int   bad_h  = 0;
        int   n_t0   = 0;
        int   req_n;
        logic exp0;
`ifdef CLK_TICK_GEN_STEP_EN
        req_n = 2;
`else
        req_n = 0;
`endif
        do_reset();
        for (int c = 1; c <= 95; c++) begin
            mode     = (c >= 81 && c <= 85) ? 2'b01 : 2'b10;
            step_req = (c >= 6 && c <= 55) || (c >= 66 && c <= 75) || (c >= 86 && c <= 90);
            cyc();
`ifdef CLK_TICK_GEN_STEP_EN
            exp0 = (c == 6) || (c == 66);
`else
            exp0 = 1'b0;
`endif
            if (tick[0] !== exp0) bad_t0++;
            if (tick[0] === 1'b1) n_t0++;
            if (halted !== 1'b1) bad_h++;
        end
        mode     = 2'b00;
        step_req = 1'b0;
        checks++;
        if (bad_t0 !== 0) begin
            failures++;
            $display("FAIL step tick0: %0d wrong cycles, required 0", bad_t0);
        end
        checks++;
        if (n_t0 !== req_n) begin
            failures++;
            $display("FAIL step tick0 total: got %0d, required %0d", n_t0, req_n);
        end
        checks++;
        if (tick0_count !== 32'(req_n)) begin
            failures++;
            $display("FAIL step count: got %0d, required %0d", tick0_count, req_n);
        end
        checks++;
        if (bad_h !== 0) begin
            failures++;
            $display("FAIL step halted: %0d wrong cycles, required 0", bad_h);
        end
    endtask

    task automatic test_mid_reset();
        int bad_t = 0;
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) begin
                div_we    = 2'b11;
                div_wdata = 32'd1;
            end else if (c == 3) begin
                div_we    = 2'b11;
                div_wdata = 32'd10;
            end else begin
                div_we = 2'b00;
            end
            mode = (c == 6) ? 2'b01 : 2'b00;
            cyc();
        end
        checks++;
        if (tick0_count !== 32'd1 || halted !== 1'b1 || phase !== 2'b11 || tick !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset before: count=%0d halted=%b phase=%b tick=%b, required 1 1 11 00",
                     tick0_count, halted, phase, tick);
        end
        rst  = 1'b1;
        mode = 2'b00;
        cyc();
        checks++;
        if (tick0_count !== 32'd0 || halted !== 1'b0 || phase !== 2'b00 || tick !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset after: count=%0d halted=%b phase=%b tick=%b, required 0 0 00 00",
                     tick0_count, halted, phase, tick);
        end
        rst = 1'b0;
        for (int p = 1; p <= 10000; p++) begin
            cyc();
            if (tick !== ((p == 10000) ? 2'b11 : 2'b00)) bad_t++;
        end
        checks++;
        if (bad_t !== 0) begin
            failures++;
            $display("FAIL mid_reset restart: %0d wrong tick cycles, required 0", bad_t);
        end
    endtask

    initial begin
        test_reset();
        test_run_default();
        test_div_write();
        test_div_zero_one();
        test_halt_run();
        test_step();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
